// File: rtl/mem_arb_n.sv
// mem_arb_n: N-port memory bus arbiter with fixed/round-robin selection and bus-timeout watchdog
module mem_arb_n #(
   parameter int NPORTS  = 2,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 0,
   parameter int TW      = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NPORTS-1:0]      req_valid,
   output logic [NPORTS-1:0]      req_ready,
   input  logic [32*NPORTS-1:0]   req_addr,
   input  logic [32*NPORTS-1:0]   req_wdata,
   input  logic [4*NPORTS-1:0]    req_wstrb,
   output logic [32*NPORTS-1:0]   req_rdata,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_wstrb,
   input  logic [31:0]            mem_rdata,
   output logic [NPORTS-1:0]      grant,
   output logic                   fault
);
   localparam int PW = $clog2(NPORTS);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [NPORTS-1:0] grant_q, grant_d, pick;
   logic [PW-1:0] ptr_q, ptr_d, g;
   logic [TW-1:0] wd_q, wd_d;
   logic fault_q, fault_d, busy, done, timeout;
   always_comb begin
      g = '0;
      for (int i = 0; i < NPORTS; i++) if (grant_q[i]) g = PW'(i);
   end
   // ptr_q is the first index searched; fixed priority always searches from 0
   always_comb begin
      int idx;
      pick = '0;
      for (int i = NPORTS - 1; i >= 0; i--) begin
         idx = (RR_MODE != 0) ? int'(ptr_q) + i : i;
         if (idx >= NPORTS) idx = idx - NPORTS;
         if (req_valid[idx]) begin
            pick = '0;
            pick[idx] = 1'b1;
         end
      end
   end
   assign busy    = state_q == BUSY;
   assign done    = mem_valid & mem_ready;
   assign timeout = (TIMEOUT != 0) && (wd_q == TW'(TIMEOUT - 1));
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      fault_d = fault_q;
      if (!busy) begin
         if (|req_valid) begin
            state_d = BUSY;
            grant_d = pick;
            wd_d    = '0;
         end
      end else if (done) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d   = (RR_MODE != 0) ? ((g == PW'(NPORTS - 1)) ? '0 : g + 1'b1) : ptr_q;
      end else if (!req_valid[g] || timeout) begin
         state_d = IDLE;
         grant_d = '0;
         fault_d = fault_q | timeout;
      end else begin
         wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
      end
   end
   always_comb begin
      mem_valid = busy & req_valid[g];
      mem_addr  = busy ? req_addr[32*g +: 32] : '0;
      mem_wdata = busy ? req_wdata[32*g +: 32] : '0;
      mem_wstrb = busy ? req_wstrb[4*g +: 4] : '0;
      req_ready = (busy & req_valid[g] & mem_ready) ? grant_q : '0;
      req_rdata = '0;
      for (int i = 0; i < NPORTS; i++) req_rdata[32*i +: 32] = grant_q[i] ? mem_rdata : '0;
      grant = grant_q;
      fault = fault_q;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         fault_q <= fault_d;
      end
   end
endmodule

// File: tb/tb_mem_arb_n.sv
// tb_mem_arb_n: directed checks of a fixed-priority/watchdog instance and a round-robin instance
module tb_mem_arb_n;
   logic clk = 1'b0, rstn = 1'b0, mem_ready = 1'b0;
   logic [3:0] req_valid = '0;
   logic [127:0] req_addr = '0, req_wdata = '0;
   logic [15:0] req_wstrb = '0;
   logic [31:0] mem_rdata = '0;
   logic [3:0] req_ready_a, req_ready_b, grant_a, grant_b;
   logic [127:0] req_rdata_a, req_rdata_b;
   logic mem_valid_a, mem_valid_b, fault_a, fault_b;
   logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
   logic [3:0] mem_wstrb_a, mem_wstrb_b;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   mem_arb_n #(.NPORTS(4), .RR_MODE(0), .TIMEOUT(5), .TW(16)) u_a (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_a),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata_a),
      .mem_valid(mem_valid_a), .mem_ready(mem_ready), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_wstrb(mem_wstrb_a), .mem_rdata(mem_rdata), .grant(grant_a), .fault(fault_a));
   mem_arb_n #(.NPORTS(4), .RR_MODE(1), .TIMEOUT(0), .TW(16)) u_b (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_b),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata_b),
      .mem_valid(mem_valid_b), .mem_ready(mem_ready), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_wstrb(mem_wstrb_b), .mem_rdata(mem_rdata), .grant(grant_b), .fault(fault_b));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask
   initial begin
      req_addr[63:32]   = 32'h200;
      req_addr[127:96]  = 32'h300;
      req_wdata[63:32]  = 32'h1111_2222;
      req_wstrb[7:4]    = 4'b0011;
      req_wstrb[15:12]  = 4'b1111;
      mem_rdata         = 32'hDEAD_BEEF;
      tick();
      tick();
      chk("rst_grant", 32'(grant_a), 0);
      chk("rst_mem_valid", 32'(mem_valid_a), 0);
      chk("rst_req_ready", 32'(req_ready_a), 0);
      chk("rst_fault", 32'(fault_a), 0);
      chk("rst_mem_addr", mem_addr_a, 0);
      rstn = 1'b1;
      // basic read from port 0, memory ready on the second BUSY cycle
      req_addr[31:0] = 32'h100;
      req_valid = 4'b0001;
      #1 chk("t1_idle_valid", 32'(mem_valid_a), 0);
      tick();
      chk("t1_grant", 32'(grant_a), 32'h1);
      chk("t1_mem_valid", 32'(mem_valid_a), 1);
      chk("t1_mem_addr", mem_addr_a, 32'h100);
      chk("t1_no_ready", 32'(req_ready_a), 0);
      tick();
      mem_ready = 1'b1;
      #1 chk("t1_ready", 32'(req_ready_a), 32'h1);
      chk("t1_rdata0", req_rdata_a[31:0], 32'hDEAD_BEEF);
      chk("t1_rdata1", req_rdata_a[63:32], 0);
      tick();
      req_valid = 4'b0000;
      #1 chk("t1_done_grant", 32'(grant_a), 0);
      chk("t1_done_ready", 32'(req_ready_a), 0);
      // fixed priority: port 1 always beats port 3
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_grant", 32'(grant_a), 32'h2);
         chk("t2_wstrb", 32'(mem_wstrb_a), 32'h3);
         chk("t2_addr", mem_addr_a, 32'h200);
         chk("t2_wdata", mem_wdata_a, 32'h1111_2222);
         chk("t2_ready", 32'(req_ready_a), 32'h2);
         tick();
         chk("t2_idle", 32'(grant_a), 0);
      end
      // round-robin order from a fresh pointer
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t3_grant", 32'(grant_b), 32'(1 << (k % 4)));
         chk("t3_ready", 32'(req_ready_b), 32'(1 << (k % 4)));
         tick();
         chk("t3_idle", 32'(grant_b), 0);
      end
      // reset in the middle of a transaction
      req_valid = 4'b0010;
      mem_ready = 1'b0;
      tick();
      chk("t4_grant", 32'(grant_b), 32'h2);
      rstn = 1'b0;
      tick();
      chk("t4_grant_rst", 32'(grant_b), 0);
      chk("t4_valid_rst", 32'(mem_valid_b), 0);
      chk("t4_ready_rst", 32'(req_ready_b), 0);
      rstn = 1'b1;
      // requester drops valid mid-transaction; pointer must stay at 0
      tick();
      chk("t6_grant", 32'(grant_b), 32'h2);
      req_valid = 4'b0000;
      mem_ready = 1'b1;
      #1 chk("t6_valid_drop", 32'(mem_valid_b), 0);
      chk("t6_no_ready", 32'(req_ready_b), 0);
      tick();
      chk("t6_idle", 32'(grant_b), 0);
      req_valid = 4'b1001;
      tick();
      chk("t6_ptr_kept", 32'(grant_b), 32'h1);
      req_valid = 4'b0000;
      tick();
      // watchdog abort after five BUSY cycles
      mem_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_busy_grant", 32'(grant_a), 32'h1);
         chk("t5_fault_pre", 32'(fault_a), 0);
      end
      tick();
      chk("t5_abort_grant", 32'(grant_a), 0);
      chk("t5_fault", 32'(fault_a), 1);
      chk("t5_no_ready", 32'(req_ready_a), 0);
      req_valid = 4'b0010;
      mem_ready = 1'b1;
      tick();
      chk("t5_next_grant", 32'(grant_a), 32'h2);
      chk("t5_next_ready", 32'(req_ready_a), 32'h2);
      req_valid = 4'b0000;
      tick();
      chk("t5_sticky", 32'(fault_a), 1);
      // completion coinciding with the timeout cycle wins
      do_reset();
      chk("t5_fault_clr", 32'(fault_a), 0);
      mem_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) tick();
      chk("t5c_grant", 32'(grant_a), 32'h1);
      mem_ready = 1'b1;
      #1 chk("t5c_ready", 32'(req_ready_a), 32'h1);
      tick();
      req_valid = 4'b0000;
      #1 chk("t5c_fault", 32'(fault_a), 0);
      tick();
      chk("t5c_idle", 32'(grant_a), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
